pe_feeder: RTL and testbench

- Sequencer that drives one pro_ele-style processing element (PE).
- Fetches a neuron's weight and input vectors from two synchronous read memories and issues the PE header cycle carrying count and bias.
- Streams one w/x pair per cycle, flushes with zero pairs, captures the PE result and returns it on a start/valid handshake.
- Sits between the layer controller and each PE instance.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/pe_addr_gen.sv | 66 ++++++
 rtl/pe_feeder.sv | 141 ++++++++++++++
 tb/tb_pe_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the PE feeder: sequencer states, FP32 constants, header layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nn_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 10;
  localparam int CNT_W_DEF   = 10;

  // Bit position of the element count inside the PE header word on pe_x.
  localparam int HDR_CNT_LSB = 0;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_STREAM,
    ST_DRAIN,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pe_addr_gen.sv
// Address generator: latches bases and count, issues one read per cycle, flags the last pair.
// Latency: first read issued the cycle after load; each later read one cycle after the previous.
// Backpressure: none; advances whenever issue/advance are asserted by the sequencer.
module pe_addr_gen
  import nn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic              issue,
  input  logic              advance,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic              last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] next_idx;  // index of the next element still to be read
  logic [CNT_W-1:0] pair_idx;  // index of the pair currently on the PE operands

  // Only meaningful while streaming, where cnt_q is known to be non-zero.
  assign last = (pair_idx == (cnt_q - CNT_W'(1)));

  // Base latch on load, then one address step per issue cycle while reads remain.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      next_idx  <= '0;
      pair_idx  <= '0;
      mem_rd_en <= 1'b0;
      w_addr    <= '0;
      x_addr    <= '0;
    end else if (load) begin
      cnt_q     <= count;
      next_idx  <= CNT_W'(1);
      pair_idx  <= '0;
      w_addr    <= w_base;
      x_addr    <= x_base;
      mem_rd_en <= (count != '0);
    end else begin
      if (issue) begin
        if (next_idx < cnt_q) begin
          w_addr    <= w_addr + ADDR_W'(1);
          x_addr    <= x_addr + ADDR_W'(1);
          next_idx  <= next_idx + CNT_W'(1);
          mem_rd_en <= 1'b1;
        end else begin
          mem_rd_en <= 1'b0;
        end
      end else begin
        mem_rd_en <= 1'b0;
      end
      if (advance) begin
        pair_idx <= pair_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Sequences one PE: header, count w/x pairs from memory, zero flush pair, result capture.
// Latency: start accepted in cycle 0 gives result_valid in cycle count+4 (ReLU via PE_FEEDER_RELU_EN).
// Backpressure: ready is high only in IDLE; start elsewhere is ignored, nothing is queued.
module pe_feeder
  import nn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] bias,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              pe_error,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic [DATA_W-1:0] x_rdata,
  output logic              pe_head,
  output logic [DATA_W-1:0] pe_w,
  output logic [DATA_W-1:0] pe_x,
  output logic [DATA_W-1:0] pe_b,
  input  logic [DATA_W-1:0] pe_out,
  input  logic              pe_done
);

  state_t            state;
  logic              stream_vld;
  logic [CNT_W-1:0]  count_q;
  logic              pair_last;
  logic              load;
  logic [DATA_W-1:0] zero_word;
  logic [DATA_W-1:0] hdr_word;
  logic [DATA_W-1:0] captured;

  assign load      = (state == ST_IDLE) && start;
  assign zero_word = DATA_W'(FP32_ZERO);
  assign hdr_word  = DATA_W'(count_q) << HDR_CNT_LSB;

  // Memory data goes straight to the PE; everywhere else the operands are zero so the
  // PE accumulator cannot drift, and the flush pair in DRAIN is a true 0*0.
  assign pe_w = stream_vld ? w_rdata : zero_word;
  assign pe_x = stream_vld ? x_rdata : (pe_head ? hdr_word : zero_word);

`ifdef PE_FEEDER_RELU_EN
  // Sign bit alone decides, so -0.0 also clamps to +0.0.
  assign captured = pe_out[DATA_W-1] ? zero_word : pe_out;
`else
  assign captured = pe_out;
`endif

  pe_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clock     (clock),
    .rst_n     (rst_n),
    .load      (load),
    .issue     ((state == ST_HEAD) || (state == ST_STREAM)),
    .advance   (state == ST_STREAM),
    .count     (count),
    .w_base    (w_base),
    .x_base    (x_base),
    .mem_rd_en (mem_rd_en),
    .w_addr    (w_addr),
    .x_addr    (x_addr),
    .last      (pair_last)
  );

  // Sequencer FSM with registered handshake and PE control outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      pe_error     <= 1'b0;
      pe_head      <= 1'b0;
      pe_b         <= '0;
      stream_vld   <= 1'b0;
      count_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count_q <= count;
            pe_b    <= bias;
            pe_head <= 1'b1;
            ready   <= 1'b0;
            state   <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          pe_head <= 1'b0;
          if (count_q != '0) begin
            stream_vld <= 1'b1;
            state      <= ST_STREAM;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_STREAM: begin
          if (pair_last) begin
            stream_vld <= 1'b0;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // pe_done is a level check here only; it may legitimately stay high across headers.
          result       <= captured;
          result_valid <= 1'b1;
          if (!pe_done) begin
            pe_error <= 1'b1;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized scoreboard bench for pe_feeder with a behavioural PE and memories.
// Latency: expectations are timestamped in cycles relative to start acceptance.
// Backpressure: waits on ready before each request, all waits bounded.
module tb_pe_feeder;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  count = '0;
  logic [31:0] bias = '0;
  logic [9:0]  w_base = '0;
  logic [9:0]  x_base = '0;
  logic        ready;
  logic [31:0] result;
  logic        result_valid;
  logic        pe_error;
  logic        mem_rd_en;
  logic [9:0]  w_addr;
  logic [9:0]  x_addr;
  logic [31:0] w_rdata = '0;
  logic [31:0] x_rdata = '0;
  logic        pe_head;
  logic [31:0] pe_w;
  logic [31:0] pe_x;
  logic [31:0] pe_b;
  logic [31:0] pe_out_m = '0;
  logic        pe_done_m = 1'b0;
  logic        done_ok = 1'b1;
  logic        pe_done;

  assign pe_done = pe_done_m & done_ok;

  pe_feeder dut (
    .clock(clock), .rst_n(rst_n), .start(start), .count(count), .bias(bias),
    .w_base(w_base), .x_base(x_base), .ready(ready), .result(result),
    .result_valid(result_valid), .pe_error(pe_error), .mem_rd_en(mem_rd_en),
    .w_addr(w_addr), .x_addr(x_addr), .w_rdata(w_rdata), .x_rdata(x_rdata),
    .pe_head(pe_head), .pe_w(pe_w), .pe_x(pe_x), .pe_b(pe_b),
    .pe_out(pe_out_m), .pe_done(pe_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic real fp2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    real         a;
    int          e;
    logic        s;
    logic [22:0] man;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    for (int i = 0; i < 300 && a >= 2.0; i++) begin a = a / 2.0; e++; end
    for (int i = 0; i < 300 && a < 1.0; i++) begin a = a * 2.0; e--; end
    man = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), man};
  endfunction

  // Synchronous-read memories with one cycle of latency.
  logic [31:0] wmem [1024];
  logic [31:0] xmem [1024];
  always @(posedge clock) begin
    if (mem_rd_en) begin
      w_rdata <= wmem[w_addr];
      x_rdata <= xmem[x_addr];
    end
  end

  // Behavioural PE: header loads count and bias, then count+1 pairs (incl. the zero flush) accumulate.
  int  pe_rem = 0;
  real pe_acc = 0.0;
  real pe_bias = 0.0;
  always @(posedge clock) begin
    if (pe_head) begin
      pe_acc    = 0.0;
      pe_bias   = fp2r(pe_b);
      pe_rem    = int'(pe_x[9:0]) + 1;
      pe_done_m <= 1'b0;
    end else if (pe_rem > 0) begin
      pe_acc = pe_acc + fp2r(pe_w) * fp2r(pe_x);
      pe_rem--;
      if (pe_rem == 0) begin
        pe_out_m  <= r2fp(pe_acc + pe_bias);
        pe_done_m <= 1'b1;
      end
    end
  end

  typedef struct { int cyc; logic [31:0] cnt; logic [31:0] b; } head_t;
  typedef struct { int cyc; logic [9:0] wa; logic [9:0] xa; } rd_t;
  typedef struct { int cyc; logic [31:0] d; } res_t;
  head_t head_q[$];
  rd_t   rd_q[$];
  res_t  res_q[$];

  // Monitor: pops expectations whenever the DUT presents a header, read or result.
  always @(negedge clock) begin : monitor
    head_t h;
    rd_t   r;
    res_t  q;
    if (rst_n) begin
      if (pe_head) begin
        if (head_q.size() == 0) chk("unexpected pe_head", 32'd1, 32'd0);
        else begin
          h = head_q.pop_front();
          chk("head cycle", 32'(cyc), 32'(h.cyc));
          chk("head pe_x count", pe_x, h.cnt);
          chk("head pe_b", pe_b, h.b);
          chk("head pe_w", pe_w, 32'h0);
        end
      end
      if (mem_rd_en) begin
        if (rd_q.size() == 0) chk("unexpected mem_rd_en", 32'd1, 32'd0);
        else begin
          r = rd_q.pop_front();
          chk("read cycle", 32'(cyc), 32'(r.cyc));
          chk("w_addr", 32'(w_addr), 32'(r.wa));
          chk("x_addr", 32'(x_addr), 32'(r.xa));
        end
      end
      if (result_valid) begin
        if (res_q.size() == 0) chk("unexpected result_valid", 32'd1, 32'd0);
        else begin
          q = res_q.pop_front();
          chk("result cycle", 32'(cyc), 32'(q.cyc));
          chk("result", result, q.d);
          chk("pe_error", 32'(pe_error), 32'(exp_err));
          chk("ready low in DONE", 32'(ready), 32'd0);
        end
      end
    end
  end

  real dw [16];
  real dx [16];

  // Fill memories and compute the neuron value from plain arithmetic.
  task automatic setup(input int cnt, input logic [9:0] wb, input logic [9:0] xb, input real b,
                       input bit rnd, output logic [31:0] bb, output logic [31:0] expv);
    real        tot;
    logic [9:0] a;
    tot = b;
    for (int i = 0; i < cnt; i++) begin
      if (rnd) begin
        dw[i] = real'($urandom_range(0, 8)) - 4.0;
        dx[i] = real'($urandom_range(0, 8)) - 4.0;
      end
      a = wb + 10'(i);
      wmem[a] = r2fp(dw[i]);
      a = xb + 10'(i);
      xmem[a] = r2fp(dx[i]);
      tot = tot + dw[i] * dx[i];
    end
    bb   = r2fp(b);
    expv = r2fp(tot);
`ifdef PE_FEEDER_RELU_EN
    if (expv[31]) expv = 32'h0;
`endif
  endtask

  task automatic push_exp(input int c0, input int cnt, input logic [9:0] wb, input logic [9:0] xb,
                          input logic [31:0] bb, input logic [31:0] expv);
    head_q.push_back('{c0 + 1, 32'(cnt), bb});
    for (int k = 0; k < cnt; k++) rd_q.push_back('{c0 + 1 + k, wb + 10'(k), xb + 10'(k)});
    res_q.push_back('{c0 + cnt + 4, expv});
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (ready) return;
    end
    chk("ready timeout", 32'd0, 32'd1);
  endtask

  // Caller is at a negedge with ready high; start is sampled at the coming edge (cycle c0).
  task automatic launch(input int cnt, input logic [9:0] wb, input logic [9:0] xb,
                        input logic [31:0] bb, input logic [31:0] expv, output int c0);
    count  = 10'(cnt);
    bias   = bb;
    w_base = wb;
    x_base = xb;
    start  = 1'b1;
    c0     = cyc;
    push_exp(c0, cnt, wb, xb, bb, expv);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst result", result, 32'h0);
    chk("rst result_valid", 32'(result_valid), 32'd0);
    chk("rst pe_error", 32'(pe_error), 32'd0);
    chk("rst pe_head", 32'(pe_head), 32'd0);
    chk("rst pe_b", pe_b, 32'h0);
    chk("rst mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst addrs", {12'h0, w_addr, x_addr}, 32'h0);
    chk("rst pe_w", pe_w, 32'h0);
    chk("rst pe_x", pe_x, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bb, ev, bb2, ev2;
    int c0, cnt, dd;
    logic [9:0] wb, xb;

    #12;
    chk_reset_outs();
    @(negedge clock);
    rst_n = 1'b1;

    // Directed: 1*1 + 2*1 + 3*1 + 0.5 = 6.5
    wait_ready();
    dw[0] = 1.0; dw[1] = 2.0; dw[2] = 3.0;
    dx[0] = 1.0; dx[1] = 1.0; dx[2] = 1.0;
    setup(3, 10'd16, 10'd48, 0.5, 1'b0, bb, ev);
    launch(3, 10'd16, 10'd48, bb, 32'h40D0_0000, c0);

    // count = 0 returns the bias with no memory reads.
    wait_ready();
    setup(0, 10'd0, 10'd0, 1.0, 1'b0, bb, ev);
    launch(0, 10'd0, 10'd0, bb, 32'h3F80_0000, c0);

    // Negative result: clamped only in the ReLU build.
    wait_ready();
    dw[0] = -2.0; dx[0] = 1.0;
    setup(1, 10'd100, 10'd200, 0.0, 1'b0, bb, ev);
`ifdef PE_FEEDER_RELU_EN
    launch(1, 10'd100, 10'd200, bb, 32'h0000_0000, c0);
`else
    launch(1, 10'd100, 10'd200, bb, 32'hC000_0000, c0);
`endif

    // Back-to-back: second start raised in DONE, must be taken only in IDLE.
    wait_ready();
    setup(4, 10'd300, 10'd400, 1.5, 1'b1, bb, ev);
    setup(3, 10'd500, 10'd600, -2.0, 1'b1, bb2, ev2);
    launch(4, 10'd300, 10'd400, bb, ev, c0);
    for (int i = 0; i < 100 && !result_valid; i++) @(negedge clock);
    chk("b2b first done seen", 32'(result_valid), 32'd1);
    count = 10'd3; bias = bb2; w_base = 10'd500; x_base = 10'd600; start = 1'b1;
    dd = cyc;
    push_exp(dd + 1, 3, 10'd500, 10'd600, bb2, ev2);
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;

    // Randomized runs with random bases (wrapping included) and idle gaps.
    for (int n = 0; n < 20; n++) begin
      wait_ready();
      cnt = $urandom_range(0, 12);
      wb  = 10'($urandom_range(0, 1023));
      xb  = 10'($urandom_range(0, 1023));
      setup(cnt, wb, xb, (real'($urandom_range(0, 16)) - 8.0) / 2.0, 1'b1, bb, ev);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      launch(cnt, wb, xb, bb, ev, c0);
    end

    // Reset during stream pair 2 of a 5-pair run, then a fresh 2-pair run.
    wait_ready();
    setup(5, 10'd700, 10'd800, 1.0, 1'b1, bb, ev);
    launch(5, 10'd700, 10'd800, bb, ev, c0);
    repeat (3) @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    head_q.delete(); rd_q.delete(); res_q.delete();
    exp_err = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    wait_ready();
    setup(2, 10'd900, 10'd950, 0.5, 1'b1, bb, ev);
    launch(2, 10'd900, 10'd950, bb, ev, c0);

    // PE never reports done: sticky error, survives the next run, cleared by reset.
    wait_ready();
    done_ok = 1'b0;
    exp_err = 1'b1;
    setup(3, 10'd10, 10'd20, 2.0, 1'b1, bb, ev);
    launch(3, 10'd10, 10'd20, bb, ev, c0);
    wait_ready();
    done_ok = 1'b1;
    setup(2, 10'h3FF, 10'h200, -1.0, 1'b1, bb, ev);
    launch(2, 10'h3FF, 10'h200, bb, ev, c0);
    wait_ready();
    chk("pe_error sticky", 32'(pe_error), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("pe_error cleared by reset", 32'(pe_error), 32'd0);
    exp_err = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      if (head_q.size() == 0 && rd_q.size() == 0 && res_q.size() == 0) break;
      @(negedge clock);
    end
    chk("leftover expectations", 32'(head_q.size() + rd_q.size() + res_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
